// File: rtl/svc_axil_pkg.sv
// Shared AXI-lite definitions: response encodings and the sequencer failure-cause enum.
package svc_axil_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_BRESP    = 2'b01,
        ERR_RRESP    = 2'b10,
        ERR_MISMATCH = 2'b11
    } err_code_t;

endpackage

// File: rtl/svc_axil_cfg_seq.sv
// AXI-lite master that writes a table of (address, data) entries after a start pulse,
// optionally reading each entry back, and stops at the first failure.
module svc_axil_cfg_seq
    import svc_axil_pkg::*;
#(
    parameter int N               = 4,
    parameter int AXIL_ADDR_WIDTH = 16,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
    parameter int VERIFY          = 0,
    localparam int IDX_W          = $clog2(N) | 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [N*AXIL_ADDR_WIDTH-1:0] cfg_addr,
    input  logic [N*AXIL_DATA_WIDTH-1:0] cfg_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [IDX_W-1:0]             err_idx,
    output logic [1:0]                   err_code,
    output logic [1:0]                   err_resp,
    output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic                         m_axil_awvalid,
    input  logic                         m_axil_awready,
    output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [AXIL_STRB_WIDTH-1:0]   m_axil_wstrb,
    output logic                         m_axil_wvalid,
    input  logic                         m_axil_wready,
    input  logic [1:0]                   m_axil_bresp,
    input  logic                         m_axil_bvalid,
    output logic                         m_axil_bready,
    output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic                         m_axil_arvalid,
    input  logic                         m_axil_arready,
    input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]                   m_axil_rresp,
    input  logic                         m_axil_rvalid,
    output logic                         m_axil_rready
);

    typedef enum logic [2:0] {
        IDLE, WR, WR_RESP, RD, RD_RESP, FIN
    } state_t;

    localparam int TAB_SIZE = 2 ** IDX_W;

    // Unpacked view of the table, padded to a power of two so idx needs no range guard.
    logic [AXIL_ADDR_WIDTH-1:0] addr_tab [TAB_SIZE];
    logic [AXIL_DATA_WIDTH-1:0] data_tab [TAB_SIZE];

    genvar gi;
    generate
        for (gi = 0; gi < TAB_SIZE; gi++) begin : g_tab
            if (gi < N) begin : g_used
                assign addr_tab[gi] = cfg_addr[gi*AXIL_ADDR_WIDTH +: AXIL_ADDR_WIDTH];
                assign data_tab[gi] = cfg_data[gi*AXIL_DATA_WIDTH +: AXIL_DATA_WIDTH];
            end else begin : g_pad
                assign addr_tab[gi] = '0;
                assign data_tab[gi] = '0;
            end
        end
    endgenerate

    state_t                     state_reg, state_next;
    logic [IDX_W-1:0]           idx_reg, idx_next;
    logic                       awvalid_reg, awvalid_next;
    logic                       wvalid_reg, wvalid_next;
    logic                       arvalid_reg, arvalid_next;
    logic [AXIL_ADDR_WIDTH-1:0] awaddr_reg, awaddr_next;
    logic [AXIL_DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [AXIL_ADDR_WIDTH-1:0] araddr_reg, araddr_next;
    logic                       err_reg, err_next;
    logic [IDX_W-1:0]           err_idx_reg, err_idx_next;
    err_code_t                  err_code_reg, err_code_next;
    logic [1:0]                 err_resp_reg, err_resp_next;

    logic                       advance;
    logic                       fail;
    err_code_t                  fail_code;
    logic [1:0]                 fail_resp;
    logic                       last_entry;

    assign last_entry = (idx_reg == IDX_W'(N - 1));

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        awvalid_next  = awvalid_reg;
        wvalid_next   = wvalid_reg;
        arvalid_next  = arvalid_reg;
        awaddr_next   = awaddr_reg;
        wdata_next    = wdata_reg;
        araddr_next   = araddr_reg;
        err_next      = err_reg;
        err_idx_next  = err_idx_reg;
        err_code_next = err_code_reg;
        err_resp_next = err_resp_reg;
        advance       = 1'b0;
        fail          = 1'b0;
        fail_code     = ERR_NONE;
        fail_resp     = AXIL_RESP_OKAY;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    idx_next      = '0;
                    err_next      = 1'b0;
                    err_idx_next  = '0;
                    err_code_next = ERR_NONE;
                    err_resp_next = AXIL_RESP_OKAY;
                    awaddr_next   = addr_tab[0];
                    wdata_next    = data_tab[0];
                    awvalid_next  = 1'b1;
                    wvalid_next   = 1'b1;
                    state_next    = WR;
                end
            end
            WR: begin
                // AW and W complete independently; a valid drops right after its own handshake.
                if (awvalid_reg && m_axil_awready) awvalid_next = 1'b0;
                if (wvalid_reg && m_axil_wready)   wvalid_next  = 1'b0;
                if (!awvalid_next && !wvalid_next) state_next   = WR_RESP;
            end
            WR_RESP: begin
                if (m_axil_bvalid) begin
                    if (m_axil_bresp != AXIL_RESP_OKAY) begin
                        fail      = 1'b1;
                        fail_code = ERR_BRESP;
                        fail_resp = m_axil_bresp;
                    end else if (VERIFY != 0) begin
                        araddr_next  = addr_tab[idx_reg];
                        arvalid_next = 1'b1;
                        state_next   = RD;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            RD: begin
                if (m_axil_arready) begin
                    arvalid_next = 1'b0;
                    state_next   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axil_rvalid) begin
                    if (m_axil_rresp != AXIL_RESP_OKAY) begin
                        fail      = 1'b1;
                        fail_code = ERR_RRESP;
                        fail_resp = m_axil_rresp;
                    end else if (m_axil_rdata != data_tab[idx_reg]) begin
                        fail      = 1'b1;
                        fail_code = ERR_MISMATCH;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (advance) begin
            if (last_entry) begin
                state_next = FIN;
            end else begin
                idx_next     = idx_reg + 1'b1;
                awaddr_next  = addr_tab[idx_next];
                wdata_next   = data_tab[idx_next];
                awvalid_next = 1'b1;
                wvalid_next  = 1'b1;
                state_next   = WR;
            end
        end

        if (fail) begin
            err_next      = 1'b1;
            err_idx_next  = idx_reg;
            err_code_next = fail_code;
            err_resp_next = fail_resp;
            state_next    = FIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            awvalid_reg  <= 1'b0;
            wvalid_reg   <= 1'b0;
            arvalid_reg  <= 1'b0;
            awaddr_reg   <= '0;
            wdata_reg    <= '0;
            araddr_reg   <= '0;
            err_reg      <= 1'b0;
            err_idx_reg  <= '0;
            err_code_reg <= ERR_NONE;
            err_resp_reg <= AXIL_RESP_OKAY;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            awvalid_reg  <= awvalid_next;
            wvalid_reg   <= wvalid_next;
            arvalid_reg  <= arvalid_next;
            awaddr_reg   <= awaddr_next;
            wdata_reg    <= wdata_next;
            araddr_reg   <= araddr_next;
            err_reg      <= err_next;
            err_idx_reg  <= err_idx_next;
            err_code_reg <= err_code_next;
            err_resp_reg <= err_resp_next;
        end
    end

    assign busy           = (state_reg != IDLE) && (state_reg != FIN);
    assign done           = (state_reg == FIN);
    assign err            = err_reg;
    assign err_idx        = err_idx_reg;
    assign err_code       = err_code_reg;
    assign err_resp       = err_resp_reg;
    assign m_axil_awaddr  = awaddr_reg;
    assign m_axil_awvalid = awvalid_reg;
    assign m_axil_wdata   = wdata_reg;
    assign m_axil_wstrb   = '1;
    assign m_axil_wvalid  = wvalid_reg;
    assign m_axil_bready  = (state_reg == WR_RESP);
    assign m_axil_araddr  = araddr_reg;
    assign m_axil_arvalid = arvalid_reg;
    assign m_axil_rready  = (state_reg == RD_RESP);

endmodule

// File: tb/tb_svc_axil_cfg_seq.sv
// Bench for svc_axil_cfg_seq: a write-only DUT and a read-back DUT share one register-file
// slave model; expected outcomes are queued at start and checked when done pulses.
module tb_svc_axil_cfg_seq;

    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sel = 1'b0;
    logic slave_rst = 1'b0;
    int   aw_stall_cfg = 0;
    logic corrupt = 1'b0;

    // DUT0: N=3, no read-back
    logic            start0 = 1'b0;
    logic [3*AW-1:0] d0_cfg_addr = '0;
    logic [3*DW-1:0] d0_cfg_data = '0;
    logic d0_busy, d0_done, d0_err;
    logic [2:0] d0_err_idx;
    logic [1:0] d0_err_code, d0_err_resp;
    logic [AW-1:0] d0_awaddr, d0_araddr;
    logic [DW-1:0] d0_wdata;
    logic [3:0] d0_wstrb;
    logic d0_awvalid, d0_wvalid, d0_bready, d0_arvalid, d0_rready;

    // DUT1: N=2, read-back
    logic            start1 = 1'b0;
    logic [2*AW-1:0] d1_cfg_addr = '0;
    logic [2*DW-1:0] d1_cfg_data = '0;
    logic d1_busy, d1_done, d1_err;
    logic [0:0] d1_err_idx;
    logic [1:0] d1_err_code, d1_err_resp;
    logic [AW-1:0] d1_awaddr, d1_araddr;
    logic [DW-1:0] d1_wdata;
    logic [3:0] d1_wstrb;
    logic d1_awvalid, d1_wvalid, d1_bready, d1_arvalid, d1_rready;

    // Slave side of the shared bus
    logic          s_awready, s_wready, s_arready;
    logic          s_bvalid, s_rvalid;
    logic [1:0]    s_bresp, s_rresp;
    logic [DW-1:0] s_rdata;
    wire  [AW-1:0] s_awaddr  = sel ? d1_awaddr  : d0_awaddr;
    wire           s_awvalid = sel ? d1_awvalid : d0_awvalid;
    wire  [DW-1:0] s_wdata   = sel ? d1_wdata   : d0_wdata;
    wire           s_wvalid  = sel ? d1_wvalid  : d0_wvalid;
    wire           s_bready  = sel ? d1_bready  : d0_bready;
    wire  [AW-1:0] s_araddr  = sel ? d1_araddr  : d0_araddr;
    wire           s_arvalid = sel ? d1_arvalid : d0_arvalid;
    wire           s_rready  = sel ? d1_rready  : d0_rready;

    svc_axil_cfg_seq #(.N(3), .AXIL_ADDR_WIDTH(AW), .AXIL_DATA_WIDTH(DW), .VERIFY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .cfg_addr(d0_cfg_addr), .cfg_data(d0_cfg_data),
        .busy(d0_busy), .done(d0_done), .err(d0_err),
        .err_idx(d0_err_idx), .err_code(d0_err_code), .err_resp(d0_err_resp),
        .m_axil_awaddr(d0_awaddr), .m_axil_awvalid(d0_awvalid), .m_axil_awready(!sel && s_awready),
        .m_axil_wdata(d0_wdata), .m_axil_wstrb(d0_wstrb), .m_axil_wvalid(d0_wvalid),
        .m_axil_wready(!sel && s_wready),
        .m_axil_bresp(s_bresp), .m_axil_bvalid(!sel && s_bvalid), .m_axil_bready(d0_bready),
        .m_axil_araddr(d0_araddr), .m_axil_arvalid(d0_arvalid), .m_axil_arready(!sel && s_arready),
        .m_axil_rdata(s_rdata), .m_axil_rresp(s_rresp), .m_axil_rvalid(!sel && s_rvalid),
        .m_axil_rready(d0_rready)
    );

    svc_axil_cfg_seq #(.N(2), .AXIL_ADDR_WIDTH(AW), .AXIL_DATA_WIDTH(DW), .VERIFY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .cfg_addr(d1_cfg_addr), .cfg_data(d1_cfg_data),
        .busy(d1_busy), .done(d1_done), .err(d1_err),
        .err_idx(d1_err_idx), .err_code(d1_err_code), .err_resp(d1_err_resp),
        .m_axil_awaddr(d1_awaddr), .m_axil_awvalid(d1_awvalid), .m_axil_awready(sel && s_awready),
        .m_axil_wdata(d1_wdata), .m_axil_wstrb(d1_wstrb), .m_axil_wvalid(d1_wvalid),
        .m_axil_wready(sel && s_wready),
        .m_axil_bresp(s_bresp), .m_axil_bvalid(sel && s_bvalid), .m_axil_bready(d1_bready),
        .m_axil_araddr(d1_araddr), .m_axil_arvalid(d1_arvalid), .m_axil_arready(sel && s_arready),
        .m_axil_rdata(s_rdata), .m_axil_rresp(s_rresp), .m_axil_rvalid(sel && s_rvalid),
        .m_axil_rready(d1_rready)
    );

    // Register-file slave: 5 words, only words 0 and 2 writable, beyond word 4 is DECERR.
    localparam logic [4:0] WMASK = 5'b00101;
    logic [DW-1:0] regs [5];
    logic          aw_got, w_got, prev_wait;
    logic [AW-1:0] wr_addr, prev_addr;
    logic [DW-1:0] wr_data;
    int            wait_cnt, aw_hs_cnt, w_hs_cnt, ar_hs_cnt, viol_cnt, done_cnt;
    wire  [13:0]   widx = wr_addr[15:2];
    wire  [13:0]   ridx = s_araddr[15:2];

    assign s_awready = !aw_got && (wait_cnt >= aw_stall_cfg);
    assign s_wready  = !w_got;
    assign s_arready = !s_rvalid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || slave_rst) begin
            regs[0] <= '0; regs[1] <= '0; regs[2] <= 32'h1234_5678; regs[3] <= '0; regs[4] <= '0;
            aw_got <= 1'b0; w_got <= 1'b0; prev_wait <= 1'b0;
            wr_addr <= '0; wr_data <= '0; prev_addr <= '0;
            s_bvalid <= 1'b0; s_bresp <= 2'b00;
            s_rvalid <= 1'b0; s_rresp <= 2'b00; s_rdata <= '0;
            wait_cnt <= 0; aw_hs_cnt <= 0; w_hs_cnt <= 0; ar_hs_cnt <= 0;
            viol_cnt <= 0; done_cnt <= 0;
        end else begin
            if ((s_awvalid && aw_got) || (s_wvalid && w_got) ||
                (prev_wait && (!s_awvalid || s_awaddr != prev_addr)))
                viol_cnt <= viol_cnt + 1;
            prev_wait <= s_awvalid && !s_awready;
            prev_addr <= s_awaddr;
            if (s_awvalid && s_awready) begin
                aw_got <= 1'b1; wr_addr <= s_awaddr; aw_hs_cnt <= aw_hs_cnt + 1; wait_cnt <= 0;
            end else if (s_awvalid) begin
                wait_cnt <= wait_cnt + 1;
            end
            if (s_wvalid && s_wready) begin
                w_got <= 1'b1; wr_data <= s_wdata; w_hs_cnt <= w_hs_cnt + 1;
            end
            if (aw_got && w_got && !s_bvalid) begin
                s_bvalid <= 1'b1;
                if (widx >= 14'd5)          s_bresp <= 2'b11;
                else if (!WMASK[widx[2:0]]) s_bresp <= 2'b10;
                else begin
                    s_bresp <= 2'b00;
                    regs[widx[2:0]] <= wr_data;
                end
            end
            if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (s_arvalid && s_arready) begin
                ar_hs_cnt <= ar_hs_cnt + 1;
                s_rvalid  <= 1'b1;
                s_rresp   <= (ridx < 14'd5) ? 2'b00 : 2'b11;
                s_rdata   <= ((ridx < 14'd5) ? regs[ridx[2:0]] : '0) ^ {{(DW-1){1'b0}}, corrupt};
            end
            if (s_rvalid && s_rready) s_rvalid <= 1'b0;
            if (sel ? d1_done : d0_done) done_cnt <= done_cnt + 1;
        end
    end

    wire       cur_done = sel ? d1_done : d0_done;
    wire       cur_busy = sel ? d1_busy : d0_busy;
    wire       cur_err  = sel ? d1_err  : d0_err;
    wire [2:0] cur_idx  = sel ? {2'b00, d1_err_idx} : d0_err_idx;
    wire [1:0] cur_code = sel ? d1_err_code : d0_err_code;
    wire [1:0] cur_resp = sel ? d1_err_resp : d0_err_resp;

    typedef struct {
        logic       err;
        logic [2:0] idx;
        logic [1:0] code;
        logic [1:0] resp;
    } exp_t;
    exp_t sb [$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set0(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        d0_cfg_addr[i*AW +: AW] = a;
        d0_cfg_data[i*DW +: DW] = d;
    endtask

    task automatic set1(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        d1_cfg_addr[i*AW +: AW] = a;
        d1_cfg_data[i*DW +: DW] = d;
    endtask

    task automatic reset_slave();
        @(negedge clk); slave_rst = 1'b1;
        @(negedge clk); slave_rst = 1'b0;
    endtask

    task automatic launch(input string tag, input logic e_err, input logic [2:0] e_idx,
                          input logic [1:0] e_code, input logic [1:0] e_resp);
        exp_t e;
        e.err = e_err; e.idx = e_idx; e.code = e_code; e.resp = e_resp;
        sb.push_back(e);
        @(negedge clk);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        check({tag, "_busy"}, 32'(cur_busy), 32'd1);
    endtask

    task automatic finish_seq(input string tag);
        int   n = 0;
        exp_t e;
        while (!cur_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(cur_done), 32'd1);
        e = sb.pop_front();
        $display("txn %s: err=%0d idx=%0d code=%0d resp=%0d (cycles %0d)",
                 tag, cur_err, cur_idx, cur_code, cur_resp, n);
        check({tag, "_busy_at_done"}, 32'(cur_busy), 32'd0);
        check({tag, "_err"}, 32'(cur_err), 32'(e.err));
        if (e.err) begin
            check({tag, "_err_idx"},  32'(cur_idx),  32'(e.idx));
            check({tag, "_err_code"}, 32'(cur_code), 32'(e.code));
            check({tag, "_err_resp"}, 32'(cur_resp), 32'(e.resp));
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(cur_done), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy",    32'(d0_busy), 32'd0);
        check("rst_done",    32'(d0_done), 32'd0);
        check("rst_err",     32'(d0_err), 32'd0);
        check("rst_valids",  32'({d0_awvalid, d0_wvalid, d0_arvalid, d0_bready, d0_rready}), 32'd0);
        check("rst_err_fld", 32'({d0_err_idx, d0_err_code, d0_err_resp}), 32'd0);
        check("rst_addr",    32'(d0_awaddr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // clean write sequence
        set0(0, 16'h0000, 32'h11); set0(1, 16'h0008, 32'h0867_5309); set0(2, 16'h0000, 32'h11);
        reset_slave();
        launch("ok", 1'b0, 3'd0, 2'b00, 2'b00);
        finish_seq("ok");
        check("ok_reg0", regs[0], 32'h11);
        check("ok_reg2", regs[2], 32'h0867_5309);
        check("ok_aw_cnt", 32'(aw_hs_cnt), 32'd3);
        check("ok_done_cnt", 32'(done_cnt), 32'd1);
        check("ok_wstrb", 32'(d0_wstrb), 32'hF);

        // read-only register rejects entry 1 with SLVERR
        set0(0, 16'h0000, 32'h1); set0(1, 16'h0004, 32'hAA); set0(2, 16'h0008, 32'h2);
        reset_slave();
        launch("slverr", 1'b1, 3'd1, 2'b01, 2'b10);
        finish_seq("slverr");
        check("slverr_reg2", regs[2], 32'h1234_5678);
        check("slverr_reg0", regs[0], 32'h1);
        check("slverr_aw_cnt", 32'(aw_hs_cnt), 32'd2);
        repeat (3) @(negedge clk);
        check("slverr_sticky", 32'(d0_err), 32'd1);

        // out-of-range address on entry 0
        set0(0, 16'h0014, 32'h5); set0(1, 16'h0000, 32'h6); set0(2, 16'h0008, 32'h7);
        reset_slave();
        launch("decerr", 1'b1, 3'd0, 2'b01, 2'b11);
        finish_seq("decerr");
        repeat (2) @(negedge clk);
        check("decerr_done_cnt", 32'(done_cnt), 32'd1);

        // AW backpressure plus a start pulse while busy
        set0(0, 16'h0000, 32'h11); set0(1, 16'h0008, 32'h0867_5309); set0(2, 16'h0000, 32'h22);
        reset_slave();
        aw_stall_cfg = 3;
        launch("bp", 1'b0, 3'd0, 2'b00, 2'b00);
        repeat (2) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        finish_seq("bp");
        repeat (4) @(negedge clk);
        check("bp_aw_cnt", 32'(aw_hs_cnt), 32'd3);
        check("bp_w_cnt", 32'(w_hs_cnt), 32'd3);
        check("bp_protocol_viol", 32'(viol_cnt), 32'd0);
        check("bp_done_cnt", 32'(done_cnt), 32'd1);
        check("bp_reg0", regs[0], 32'h22);
        aw_stall_cfg = 0;

        // read-back mismatch on entry 0
        sel = 1'b1;
        set1(0, 16'h0000, 32'hCAFE); set1(1, 16'h0008, 32'hBEEF);
        reset_slave();
        corrupt = 1'b1;
        launch("mism", 1'b1, 3'd0, 2'b11, 2'b00);
        finish_seq("mism");
        check("mism_ar_cnt", 32'(ar_hs_cnt), 32'd1);

        // matching read-back
        reset_slave();
        corrupt = 1'b0;
        launch("vfy", 1'b0, 3'd0, 2'b00, 2'b00);
        finish_seq("vfy");
        check("vfy_ar_cnt", 32'(ar_hs_cnt), 32'd2);
        check("vfy_reg2", regs[2], 32'hBEEF);

        // reset asserted mid-write
        sel = 1'b0;
        aw_stall_cfg = 3;
        reset_slave();
        launch("rst", 1'b0, 3'd0, 2'b00, 2'b00);
        void'(sb.pop_front());
        check("rst_mid_awvalid_pre", 32'(d0_awvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valids", 32'({d0_awvalid, d0_wvalid}), 32'd0);
        check("rst_mid_busy", 32'(d0_busy), 32'd0);
        aw_stall_cfg = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_after_busy", 32'(d0_busy), 32'd0);
        check("rst_after_valids", 32'({d0_awvalid, d0_wvalid, d0_bready, d0_done}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
